// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID pipeline register of the 16-bit pipelined CPU.
//
// The block holds the PC and drives instruction-memory fetches. It registers the
// fetched word and its PC for the ID stage. It also applies redirect, flush, halt
// and stall requests.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   stall          hazard unit: hold PC and IF/ID this cycle
//   pc_op          control: redirect PC (branch taken or jump)
//   b_jmp          control: 1 = branch target, 0 = jump target
//   if_flush       control: discard the word being fetched
//   halt           control: stop fetching
//   imem_addr      byte address of the fetch (= pc_q)
//   imem_req       fetch request
//   imem_rdata     instruction word, valid when imem_ready = 1
//   imem_ready     memory returned imem_rdata this cycle
//   id_instr       IF/ID instruction
//   id_pc          IF/ID PC of id_instr
//   id_valid       0 = id_instr is a bubble
//   opcode         id_instr[15:12]
//   function_code  id_instr[3:0]
//   halted         CPU stopped; sticky until reset
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_op,
    input  logic        b_jmp,
    input  logic        if_flush,
    input  logic        halt,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_valid,
    output logic [3:0]  opcode,
    output logic [3:0]  function_code,
    output logic        halted
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t             state_q;
    logic        [15:0] pc_q;
    logic        [15:0] instr_p1;
    logic        [15:0] pc_p1;
    logic               vld_p1;

    logic signed [15:0] br_disp;
    logic signed [15:0] jmp_disp;
    logic        [15:0] br_target;
    logic        [15:0] jmp_target;

    // The target is pc + 2 + (displacement << 1), computed modulo 2^16.
    // Bit 0 is forced low so that pc_q always stays halfword aligned.
    function automatic logic [15:0] rel_target(input logic [15:0] base,
                                               input logic signed [15:0] disp);
        logic [15:0] sum;
        sum = base + 16'd2 + ($unsigned(disp) << 1);
        return {sum[15:1], 1'b0};
    endfunction

    assign br_disp    = {{8{instr_p1[7]}}, instr_p1[7:0]};
    assign jmp_disp   = {{4{instr_p1[11]}}, instr_p1[11:0]};
    assign br_target  = rel_target(pc_p1, br_disp);
    assign jmp_target = rel_target(pc_p1, jmp_disp);

    // IF stage: PC register, control state and fetch request
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            instr_p1 <= NOP_INSTR;
            pc_p1    <= 16'h0000;
            vld_p1   <= 1'b0;
        end else if (state_q == RUN) begin
            if (stall) begin
                // A stalled cycle holds everything.
                // Control re-asserts its requests once the stall drops.
                state_q <= RUN;
            end else if (halt) begin
                state_q  <= HALTED;
                instr_p1 <= NOP_INSTR;
                vld_p1   <= 1'b0;
            end else if (pc_op) begin
                pc_q     <= b_jmp ? br_target : jmp_target;
                instr_p1 <= NOP_INSTR;
                vld_p1   <= 1'b0;
            end else if (if_flush) begin
                // The word is dropped.
                // The fetch still counts as done if memory answered.
                if (imem_ready) pc_q <= pc_q + 16'd2;
                instr_p1 <= NOP_INSTR;
                vld_p1   <= 1'b0;
            end else if (imem_ready) begin
                pc_q     <= pc_q + 16'd2;
                instr_p1 <= imem_rdata;
                pc_p1    <= pc_q;
                vld_p1   <= 1'b1;
            end else begin
                // On a miss the same address is requested again next cycle.
                instr_p1 <= NOP_INSTR;
                vld_p1   <= 1'b0;
            end
        end
    end

    // IF/ID boundary: outputs presented to the ID stage and control
    assign imem_addr     = pc_q;
    assign imem_req      = reset && (state_q == RUN);
    assign id_instr      = instr_p1;
    assign id_pc         = pc_p1;
    assign id_valid      = vld_p1;
    assign opcode        = instr_p1[15:12];
    assign function_code = instr_p1[3:0];
    assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector bench for fetch_stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        pc_op;
    logic        b_jmp;
    logic        if_flush;
    logic        halt;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_valid;
    logic [3:0]  opcode;
    logic [3:0]  function_code;
    logic        halted;

    int errs   = 0;
    int checks = 0;

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'hF000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_op        (pc_op),
        .b_jmp        (b_jmp),
        .if_flush     (if_flush),
        .halt         (halt),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .opcode       (opcode),
        .function_code(function_code),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the fetch address and the whole IF/ID register.
    task automatic expect_if(input string tag, input logic [15:0] addr,
                             input logic [15:0] instr, input logic [15:0] pc,
                             input logic vld);
        check({tag, ".addr"},  imem_addr, addr);
        check({tag, ".instr"}, id_instr,  instr);
        if (vld) check({tag, ".pc"}, id_pc, pc);
        check({tag, ".valid"}, {15'd0, id_valid}, {15'd0, vld});
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; pc_op = 1'b0; b_jmp = 1'b0;
        if_flush = 1'b0; halt = 1'b0; imem_ready = 1'b1; imem_rdata = 16'h1123;

        // Reset held low for two cycles
        step(); step();
        expect_if("rst", 16'h0000, 16'hF000, 16'h0000, 1'b0);
        check("rst.req", {15'd0, imem_req}, 16'd0);
        check("rst.halted", {15'd0, halted}, 16'd0);

        // Sequential fetch
        reset = 1'b1;
        #1;
        check("run.req", {15'd0, imem_req}, 16'd1);
        step();
        expect_if("seq0", 16'h0002, 16'h1123, 16'h0000, 1'b1);
        check("seq0.opcode", {12'd0, opcode}, 16'h0001);
        check("seq0.fcode", {12'd0, function_code}, 16'h0003);
        imem_rdata = 16'h2234;
        step();
        expect_if("seq1", 16'h0004, 16'h2234, 16'h0002, 1'b1);

        // Jump to FFFE (word 7FFC fetched at 0004), then wrap to 0000
        imem_rdata = 16'h7FFC;
        step();
        expect_if("wrapj", 16'h0006, 16'h7FFC, 16'h0004, 1'b1);
        pc_op = 1'b1; b_jmp = 1'b0;
        step();
        expect_if("wrapr", 16'hFFFE, 16'hF000, 16'h0000, 1'b0);
        pc_op = 1'b0; imem_rdata = 16'h7007;
        step();
        expect_if("wrap", 16'h0000, 16'h7007, 16'hFFFE, 1'b1);

        // Reach 0010 with jump 7007 (fetched at FFFE: FFFE+2+0E = 000E)
        pc_op = 1'b1; b_jmp = 1'b0;
        step();
        expect_if("j10", 16'h000E, 16'hF000, 16'h0000, 1'b0);
        pc_op = 1'b0; imem_rdata = 16'h0000;
        step();
        expect_if("f0e", 16'h0010, 16'h0000, 16'h000E, 1'b1);
        imem_rdata = 16'h50FE;
        step();
        expect_if("f10", 16'h0012, 16'h50FE, 16'h0010, 1'b1);

        // Branch: 0010 + 2 - 4 = 000E
        pc_op = 1'b1; b_jmp = 1'b1;
        step();
        expect_if("br", 16'h000E, 16'hF000, 16'h0000, 1'b0);

        // Fetch 7008 at 000E -> jump to 0020
        pc_op = 1'b0; imem_rdata = 16'h7008;
        step();
        expect_if("f0e2", 16'h0010, 16'h7008, 16'h000E, 1'b1);
        pc_op = 1'b1; b_jmp = 1'b0;
        step();
        expect_if("j20", 16'h0020, 16'hF000, 16'h0000, 1'b0);
        pc_op = 1'b0; imem_rdata = 16'h7010;
        step();
        expect_if("f20", 16'h0022, 16'h7010, 16'h0020, 1'b1);

        // Jump: 0020 + 2 + 20 = 0042
        pc_op = 1'b1; b_jmp = 1'b0;
        step();
        expect_if("jmp", 16'h0042, 16'hF000, 16'h0000, 1'b0);

        // Stall overrides redirect; the redirect is taken once the stall drops
        pc_op = 1'b0; imem_rdata = 16'h5002;
        step();
        expect_if("f42", 16'h0044, 16'h5002, 16'h0042, 1'b1);
        stall = 1'b1; pc_op = 1'b1; b_jmp = 1'b1;
        step();
        expect_if("stall", 16'h0044, 16'h5002, 16'h0042, 1'b1);
        stall = 1'b0;
        step();
        expect_if("unstall", 16'h0048, 16'hF000, 16'h0000, 1'b0);

        // Go to 0006 with 7FDE fetched at 0048 (0048 + 2 - 44 = 0006)
        pc_op = 1'b0; imem_rdata = 16'h7FDE;
        step();
        expect_if("f48", 16'h004A, 16'h7FDE, 16'h0048, 1'b1);
        pc_op = 1'b1; b_jmp = 1'b0;
        step();
        expect_if("j06", 16'h0006, 16'hF000, 16'h0000, 1'b0);

        // Miss for three cycles at 0006
        pc_op = 1'b0; imem_ready = 1'b0; imem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_if("miss", 16'h0006, 16'hF000, 16'h0000, 1'b0);
        end
        imem_ready = 1'b1; imem_rdata = 16'h3456;
        step();
        expect_if("hit", 16'h0008, 16'h3456, 16'h0006, 1'b1);

        // Flush during a miss: the PC is held and a bubble is inserted
        if_flush = 1'b1; imem_ready = 1'b0;
        step();
        expect_if("flushm", 16'h0008, 16'hF000, 16'h0000, 1'b0);

        // Halt together with if_flush at 0008
        halt = 1'b1; imem_ready = 1'b1;
        step();
        expect_if("halt", 16'h0008, 16'hF000, 16'h0000, 1'b0);
        check("halt.halted", {15'd0, halted}, 16'd1);
        check("halt.req", {15'd0, imem_req}, 16'd0);
        halt = 1'b0; if_flush = 1'b0; pc_op = 1'b1; b_jmp = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halted.addr", imem_addr, 16'h0008);
            check("halted.valid", {15'd0, id_valid}, 16'd0);
        end
        check("halted.sticky", {15'd0, halted}, 16'd1);

        // Reset leaves the halted state
        reset = 1'b0; pc_op = 1'b0;
        step();
        check("rst2.addr", imem_addr, 16'h0000);
        check("rst2.halted", {15'd0, halted}, 16'd0);
        check("rst2.req", {15'd0, imem_req}, 16'd0);
        reset = 1'b1;
        #1;
        check("rst2.run", {15'd0, imem_req}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
